rvv_cmd_queue: RTL and testbench

- N-in / M-out circular command queue between the RVV frontend and `rvv_backend` issue lanes.
- Generalises the fixed-width command buffer:
  - independent IN_N / OUT_N lane counts;
  - arbitrary DEPTH, with or without power-of-two;
  - built-in clamped capacity credit for frontend back-pressure;
  - synchronous flush;
  - sticky overflow detection.
- Frontend writes a lane count each cycle; backend pops a ready-prefix each cycle.

---
 rtl/rvv_cmd_queue_pkg.sv | 39 +++
 rtl/rvv_prefix_count.sv | 23 ++
 rtl/rvv_cmd_queue.sv | 113 +++++++++++
 tb/tb_rvv_cmd_queue.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvv_cmd_queue_pkg.sv
// rtl/rvv_cmd_queue_pkg.sv - shared types and helpers for the RVV command queue
package rvv_cmd_queue_pkg;

  // Stand-in command record; integration swaps in the shared RVVCmd definition.
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] vd;
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic [9:0] ctrl;
  } RVVCmd;

  // Widest lane vector leading_ones can scan.
  localparam int unsigned MAX_LANES = 32;

  // Circular pointer advance without relying on power-of-two wrap; k <= depth.
  function automatic int unsigned wrap_add(int unsigned ptr, int unsigned k, int unsigned depth);
    int unsigned sum;
    sum = ptr + k;
    return (sum >= depth) ? (sum - depth) : sum;
  endfunction

  // Count of consecutive ones starting at bit 0, looking at the low 'width' bits only.
  function automatic int unsigned leading_ones(logic [MAX_LANES-1:0] vec, int unsigned width);
    int unsigned n;
    logic        run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (run && (unsigned'(i) < width) && vec[i]) begin
        n = n + 1;
      end else begin
        run = 1'b0;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/rvv_prefix_count.sv
// rtl/rvv_prefix_count.sv - length of the leading valid&ready run across issue lanes
module rvv_prefix_count
  import rvv_cmd_queue_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]             valid_i,
  input  logic [WIDTH-1:0]             ready_i,
  output logic [$clog2(WIDTH+1)-1:0]   count_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [MAX_LANES-1:0] hit;

  // A lane accepted after a gap does not count: only the unbroken run from lane 0 pops.
  always_comb begin
    hit              = '0;
    hit[WIDTH-1:0]   = valid_i & ready_i;
    count_o          = CW'(leading_ones(hit, WIDTH));
  end

endmodule

// File: rtl/rvv_cmd_queue.sv
// rtl/rvv_cmd_queue.sv - N-in / M-out circular command queue with capacity credit
module rvv_cmd_queue
  import rvv_cmd_queue_pkg::*;
#(
  parameter type         T         = RVVCmd,
  parameter int unsigned IN_N      = 4,
  parameter int unsigned OUT_N     = 4,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned RESERVE   = 4,
  parameter int unsigned CAP_CLAMP = 8,
  localparam int unsigned W  = $bits(T),
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned IW = $clog2(IN_N + 1),
  localparam int unsigned OW = $clog2(OUT_N + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic [IW-1:0]        in_count_i,
  input  logic [IN_N*W-1:0]    in_data_i,
  output logic [CW-1:0]        in_capacity_o,
  output logic [OUT_N-1:0]     out_valid_o,
  output logic [OUT_N*W-1:0]   out_data_o,
  input  logic [OUT_N-1:0]     out_ready_i,
  output logic [CW-1:0]        fill_level_o,
  output logic                 overflow_err_o
);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [W-1:0]  mem_q [DEPTH];

  logic [OW-1:0] pop;
  int unsigned   req;
  int unsigned   free_slots;
  int unsigned   enq;
  int unsigned   avail;
  logic [IN_N-1:0] wr_en;
  logic [PW-1:0]   wr_idx [IN_N];

  rvv_prefix_count #(
    .WIDTH (OUT_N)
  ) u_prefix (
    .valid_i (out_valid_o),
    .ready_i (out_ready_i),
    .count_o (pop)
  );

  // Read side and credit: everything here follows the registered state only.
  always_comb begin
    out_valid_o = '0;
    out_data_o  = '0;
    for (int i = 0; i < OUT_N; i++) begin
      out_valid_o[i]        = (unsigned'(i) < 32'(count_q));
      out_data_o[i*W +: W]  = mem_q[PW'(wrap_add(32'(rd_ptr_q), unsigned'(i), DEPTH))];
    end
    avail = ((32'(count_q) + RESERVE) >= DEPTH) ? 0 : (DEPTH - RESERVE - 32'(count_q));
    in_capacity_o = CW'((avail > CAP_CLAMP) ? CAP_CLAMP : avail);
  end

  // Next state: clamp the request to lanes and to free slots, pops are not credited this cycle.
  always_comb begin
    req        = (32'(in_count_i) > IN_N) ? IN_N : 32'(in_count_i);
    free_slots = DEPTH - 32'(count_q);
    enq        = (req > free_slots) ? free_slots : req;
    ovf_d      = ovf_q | (32'(in_count_i) > IN_N) | (req > free_slots);
    for (int j = 0; j < IN_N; j++) begin
      wr_idx[j] = PW'(wrap_add(32'(wr_ptr_q), unsigned'(j), DEPTH));
      wr_en[j]  = !flush_i && (unsigned'(j) < enq);
    end
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = PW'(wrap_add(32'(rd_ptr_q), 32'(pop), DEPTH));
      wr_ptr_d = PW'(wrap_add(32'(wr_ptr_q), enq, DEPTH));
      count_d  = CW'(32'(count_q) + enq - 32'(pop));
    end
  end

  // Pointer, occupancy and sticky overflow registers; reset outranks flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage carries no reset; accepted lanes land at consecutive wrapped slots.
  always_ff @(posedge clk) begin
    for (int j = 0; j < IN_N; j++) begin
      if (wr_en[j]) begin
        mem_q[wr_idx[j]] <= in_data_i[j*W +: W];
      end
    end
  end

  assign fill_level_o   = count_q;
  assign overflow_err_o = ovf_q;

endmodule

// File: tb/tb_rvv_cmd_queue.sv
// tb/tb_rvv_cmd_queue.sv - self-checking bench for rvv_cmd_queue (pow2 and non-pow2 builds)
module tb_rvv_cmd_queue;
  import rvv_cmd_queue_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Build A: defaults (IN_N=4, OUT_N=4, DEPTH=16, RESERVE=4, CAP_CLAMP=8, 32-bit entries)
  logic         a_flush;
  logic [2:0]   a_in_count;
  logic [127:0] a_in_data;
  logic [4:0]   a_cap;
  logic [3:0]   a_valid;
  logic [127:0] a_out_data;
  logic [3:0]   a_ready;
  logic [4:0]   a_fill;
  logic         a_ovf;

  // Build B: IN_N=3, OUT_N=2, DEPTH=12, RESERVE=4, CAP_CLAMP=6, 16-bit entries
  logic         b_flush;
  logic [1:0]   b_in_count;
  logic [47:0]  b_in_data;
  logic [3:0]   b_cap;
  logic [1:0]   b_valid;
  logic [31:0]  b_out_data;
  logic [1:0]   b_ready;
  logic [3:0]   b_fill;
  logic         b_ovf;

  rvv_cmd_queue dut_a (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (a_flush),
    .in_count_i     (a_in_count),
    .in_data_i      (a_in_data),
    .in_capacity_o  (a_cap),
    .out_valid_o    (a_valid),
    .out_data_o     (a_out_data),
    .out_ready_i    (a_ready),
    .fill_level_o   (a_fill),
    .overflow_err_o (a_ovf)
  );

  rvv_cmd_queue #(
    .T         (logic [15:0]),
    .IN_N      (3),
    .OUT_N     (2),
    .DEPTH     (12),
    .RESERVE   (4),
    .CAP_CLAMP (6)
  ) dut_b (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (b_flush),
    .in_count_i     (b_in_count),
    .in_data_i      (b_in_data),
    .in_capacity_o  (b_cap),
    .out_valid_o    (b_valid),
    .out_data_o     (b_out_data),
    .out_ready_i    (b_ready),
    .fill_level_o   (b_fill),
    .overflow_err_o (b_ovf)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: queue contents in arrival order plus the sticky flag.
  logic [31:0] qa[$];
  logic [15:0] qb[$];
  bit          ovf_a;
  bit          ovf_b;
  int unsigned seq;

  function automatic logic [31:0] therm(int n);
    logic [31:0] one;
    one = 32'd1;
    return (n >= 32) ? '1 : ((one << n) - 1);
  endfunction

  function automatic int exp_cap(int size, int depth, int res, int clamp);
    int a;
    a = depth - res - size;
    if (a < 0) a = 0;
    if (a > clamp) a = clamp;
    return a;
  endfunction

  function automatic int min2(int x, int y);
    return (x < y) ? x : y;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    a_flush = 1'b0; a_in_count = '0; a_in_data = '0; a_ready = '0;
    b_flush = 1'b0; b_in_count = '0; b_in_data = '0; b_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    qa.delete(); qb.delete();
    ovf_a = 1'b0; ovf_b = 1'b0;
  endtask

  // One clock on build A; the model applies the queue rules to the inputs held across the edge.
  task automatic cycle_a();
    int n_pop, req, enq, free;
    n_pop = 0;
    while (n_pop < 4 && n_pop < qa.size() && a_ready[n_pop]) n_pop++;
    free = 16 - qa.size();
    req  = (int'(a_in_count) > 4) ? 4 : int'(a_in_count);
    enq  = min2(req, free);
    if (int'(a_in_count) > 4 || req > free) ovf_a = 1'b1;
    @(posedge clk);
    #1;
    if (a_flush) qa.delete();
    else begin
      repeat (n_pop) void'(qa.pop_front());
      for (int j = 0; j < enq; j++) qa.push_back(a_in_data[j*32 +: 32]);
    end
  endtask

  task automatic cycle_b();
    int n_pop, req, enq, free;
    n_pop = 0;
    while (n_pop < 2 && n_pop < qb.size() && b_ready[n_pop]) n_pop++;
    free = 12 - qb.size();
    req  = int'(b_in_count);
    enq  = min2(req, free);
    if (req > free) ovf_b = 1'b1;
    @(posedge clk);
    #1;
    if (b_flush) qb.delete();
    else begin
      repeat (n_pop) void'(qb.pop_front());
      for (int j = 0; j < enq; j++) qb.push_back(b_in_data[j*16 +: 16]);
    end
  endtask

  task automatic push_a(int n);
    a_in_count = 3'(n);
    for (int j = 0; j < 4; j++) a_in_data[j*32 +: 32] = seq + 32'(j);
    cycle_a();
    seq = seq + n;
    a_in_count = '0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (a_valid !== 4'b0)   begin miscompares++; $display("FAIL reset_valid: got %b want 0000", a_valid); end
    vectors++; if (a_fill !== 5'd0)    begin miscompares++; $display("FAIL reset_fill: got %0d want 0", a_fill); end
    vectors++; if (a_cap !== 5'd8)     begin miscompares++; $display("FAIL reset_cap: got %0d want 8", a_cap); end
    vectors++; if (a_ovf !== 1'b0)     begin miscompares++; $display("FAIL reset_ovf: got %b want 0", a_ovf); end
    vectors++; if (b_cap !== 4'd6)     begin miscompares++; $display("FAIL reset_cap_b: got %0d want 6", b_cap); end
    vectors++; if (b_valid !== 2'b0)   begin miscompares++; $display("FAIL reset_valid_b: got %b want 00", b_valid); end
  endtask

  task automatic test_enqueue_pop();
    do_reset();
    seq = 0;
    repeat (3) push_a(4);
    vectors++; if (a_fill !== 5'd12)   begin miscompares++; $display("FAIL enq_fill: got %0d want 12", a_fill); end
    vectors++; if (a_cap !== 5'd0)     begin miscompares++; $display("FAIL enq_cap: got %0d want 0", a_cap); end
    vectors++; if (a_valid !== 4'hf)   begin miscompares++; $display("FAIL enq_valid: got %b want 1111", a_valid); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (a_out_data[i*32 +: 32] !== 32'(i)) begin
        miscompares++; $display("FAIL enq_data lane %0d: got %0d want %0d", i, a_out_data[i*32 +: 32], i);
      end
    end
    a_ready = 4'b1011;
    cycle_a();
    a_ready = '0;
    vectors++; if (a_fill !== 5'd10)   begin miscompares++; $display("FAIL gap_pop_fill: got %0d want 10", a_fill); end
    vectors++; if (a_out_data[31:0] !== 32'd2) begin miscompares++; $display("FAIL gap_pop_head: got %0d want 2", a_out_data[31:0]); end
    vectors++; if (a_cap !== 5'd2)     begin miscompares++; $display("FAIL gap_pop_cap: got %0d want 2", a_cap); end
  endtask

  task automatic test_wrap();
    int head, n;
    logic [31:0] t;
    do_reset();
    seq = 0;
    repeat (4) push_a(4);
    a_ready = 4'hf;
    repeat (3) cycle_a();
    a_ready = '0;
    repeat (2) push_a(4);
    vectors++; if (a_fill !== 5'd12) begin miscompares++; $display("FAIL wrap_fill: got %0d want 12", a_fill); end
    head = 12;
    a_ready = 4'hf;
    for (int c = 0; c < 8 && qa.size() > 0; c++) begin
      n = min2(qa.size(), 4);
      t = therm(n);
      vectors++; if (a_valid !== t[3:0]) begin miscompares++; $display("FAIL wrap_valid: got %b want %b", a_valid, t[3:0]); end
      for (int i = 0; i < n; i++) begin
        vectors++;
        if (a_out_data[i*32 +: 32] !== qa[i] || qa[i] !== 32'(head + i)) begin
          miscompares++; $display("FAIL wrap_order lane %0d: got %0d want %0d", i, a_out_data[i*32 +: 32], head + i);
        end
      end
      cycle_a();
      head = head + n;
    end
    a_ready = '0;
    vectors++; if (a_fill !== 5'd0) begin miscompares++; $display("FAIL wrap_drain_fill: got %0d want 0", a_fill); end
    vectors++; if (head != 24)      begin miscompares++; $display("FAIL wrap_drain_count: got %0d want 24", head); end
  endtask

  task automatic test_full_traffic();
    do_reset();
    seq = 0;
    repeat (4) push_a(4);
    vectors++; if (a_fill !== 5'd16) begin miscompares++; $display("FAIL full_fill: got %0d want 16", a_fill); end
    a_in_count = 3'd2;
    a_in_data  = {4{32'hbad0_0000}};
    a_ready    = 4'hf;
    cycle_a();
    a_in_count = '0;
    a_ready    = '0;
    vectors++; if (a_fill !== 5'd12)  begin miscompares++; $display("FAIL full_pop_fill: got %0d want 12", a_fill); end
    vectors++; if (a_ovf !== 1'b1)    begin miscompares++; $display("FAIL full_ovf: got %b want 1", a_ovf); end
    vectors++; if (a_out_data[31:0] !== 32'd4) begin miscompares++; $display("FAIL full_head: got %0d want 4", a_out_data[31:0]); end
    a_flush = 1'b1;
    cycle_a();
    a_flush = 1'b0;
    vectors++; if (a_ovf !== 1'b1)    begin miscompares++; $display("FAIL ovf_after_flush: got %b want 1", a_ovf); end
    vectors++; if (a_fill !== 5'd0)   begin miscompares++; $display("FAIL flush_fill_full: got %0d want 0", a_fill); end
  endtask

  task automatic test_flush();
    do_reset();
    seq = 100;
    push_a(4);
    push_a(1);
    vectors++; if (a_fill !== 5'd5) begin miscompares++; $display("FAIL pre_flush_fill: got %0d want 5", a_fill); end
    a_in_count = 3'd3;
    a_in_data  = {4{32'hdead_beef}};
    a_ready    = 4'hf;
    a_flush    = 1'b1;
    cycle_a();
    a_in_count = '0; a_ready = '0; a_flush = 1'b0;
    vectors++; if (a_fill !== 5'd0)  begin miscompares++; $display("FAIL flush_fill: got %0d want 0", a_fill); end
    vectors++; if (a_valid !== 4'b0) begin miscompares++; $display("FAIL flush_valid: got %b want 0000", a_valid); end
    vectors++; if (a_cap !== 5'd8)   begin miscompares++; $display("FAIL flush_cap: got %0d want 8", a_cap); end
    vectors++; if (a_ovf !== 1'b0)   begin miscompares++; $display("FAIL flush_ovf: got %b want 0", a_ovf); end
    push_a(1);
    vectors++; if (a_fill !== 5'd1)  begin miscompares++; $display("FAIL post_flush_fill: got %0d want 1", a_fill); end
    vectors++; if (a_out_data[31:0] !== 32'd105) begin miscompares++; $display("FAIL post_flush_head: got %0h want 105", a_out_data[31:0]); end
  endtask

  task automatic test_illegal_count();
    do_reset();
    seq = 200;
    push_a(7);
    vectors++; if (a_fill !== 5'd4) begin miscompares++; $display("FAIL illegal_fill: got %0d want 4", a_fill); end
    vectors++; if (a_ovf !== 1'b1)  begin miscompares++; $display("FAIL illegal_ovf: got %b want 1", a_ovf); end
    vectors++; if (a_out_data[127:96] !== 32'd203) begin miscompares++; $display("FAIL illegal_lane3: got %0d want 203", a_out_data[127:96]); end
  endtask

  task automatic test_random_npow2();
    int n;
    logic [31:0] t;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      b_in_count = 2'($urandom_range(0, 3));
      for (int j = 0; j < 3; j++) b_in_data[j*16 +: 16] = 16'($urandom);
      b_ready = 2'($urandom_range(0, 3));
      b_flush = ($urandom_range(0, 63) == 0);
      n = min2(qb.size(), 2);
      t = therm(n);
      vectors++; if (b_fill !== 4'(qb.size()))  begin miscompares++; $display("FAIL rnd_fill c%0d: got %0d want %0d", c, b_fill, qb.size()); end
      vectors++; if (b_fill > 4'd12)            begin miscompares++; $display("FAIL rnd_fill_bound c%0d: got %0d want <=12", c, b_fill); end
      vectors++; if (b_cap !== 4'(exp_cap(qb.size(), 12, 4, 6))) begin miscompares++; $display("FAIL rnd_cap c%0d: got %0d want %0d", c, b_cap, exp_cap(qb.size(), 12, 4, 6)); end
      vectors++; if (b_valid !== t[1:0])        begin miscompares++; $display("FAIL rnd_valid c%0d: got %b want %b", c, b_valid, t[1:0]); end
      vectors++; if (b_ovf !== ovf_b)           begin miscompares++; $display("FAIL rnd_ovf c%0d: got %b want %b", c, b_ovf, ovf_b); end
      for (int i = 0; i < n; i++) begin
        vectors++;
        if (b_out_data[i*16 +: 16] !== qb[i]) begin
          miscompares++; $display("FAIL rnd_data c%0d lane %0d: got %h want %h", c, i, b_out_data[i*16 +: 16], qb[i]);
        end
      end
      cycle_b();
    end
    b_in_count = '0; b_ready = '0; b_flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_enqueue_pop();
    test_wrap();
    test_full_traffic();
    test_flush();
    test_illegal_count();
    test_random_npow2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
